sb_drain_unit: RTL and testbench

//  Consumes committed store-buffer entries from the store buffer's sender handshake and performs each

---
 rtl/sb_drain_unit_pkg.sv | 23 ++
 rtl/sb_drain_unit.sv | 137 +++++++++++++
 tb/tb_sb_drain_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_drain_unit_pkg.sv
// Shared types for the store-buffer drain path: the entry layout handed over by the
// store buffer and the drain FSM state encoding.
package sb_drain_unit_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0]   addr;
    logic [SB_DATA_W-1:0]   data;
    logic [SB_DATA_W/8-1:0] wstrb;
    logic                   valid;
    logic                   commit;
    logic                   complete;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } drain_state_e;

endpackage

// File: rtl/sb_drain_unit.sv
// Drains committed store-buffer entries onto the D-cache write port, one store in flight,
// with bounded re-issue on cache retry responses.
module sb_drain_unit
  import sb_drain_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sb_entry_valid,
  output logic                sb_entry_ready,
  input  logic [ADDR_W-1:0]   sb_entry_addr,
  input  logic [DATA_W-1:0]   sb_entry_data,
  input  logic [DATA_W/8-1:0] sb_entry_wstrb,
  output logic                wr_req_valid_o,
  input  logic                wr_req_ready_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_resp_valid_i,
  input  logic                wr_resp_retry_i,
  output logic                busy_o,
  output logic                err_o,
  output logic [15:0]         done_cnt_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int RCNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  drain_state_e        state, state_nxt;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic [STRB_W-1:0]   hold_strb;
  logic [RCNT_W-1:0]   retry_cnt, retry_nxt;
  logic [15:0]         done_cnt;
  logic                err_q, err_nxt;
  logic                capture;
  logic [1:0]          done_inc;
  logic                accept, entry_empty, resp_ok, resp_retry;

  assign accept      = sb_entry_valid & sb_entry_ready;
  assign entry_empty = (sb_entry_wstrb == '0);
  assign resp_ok     = wr_resp_valid_i & ~wr_resp_retry_i;
  assign resp_retry  = wr_resp_valid_i & wr_resp_retry_i;

  // In RESP the receiver opens only on a clean response so the next store can follow immediately.
  always_comb begin
    sb_entry_ready = 1'b0;
    case (state)
      IDLE:    sb_entry_ready = 1'b1;
      RESP:    sb_entry_ready = resp_ok;
      default: sb_entry_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    capture   = 1'b0;
    done_inc  = 2'd0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (entry_empty) begin
            done_inc = 2'd1;
          end else begin
            capture   = 1'b1;
            retry_nxt = '0;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (wr_req_ready_i) state_nxt = RESP;
      end
      RESP: begin
        if (resp_ok) begin
          done_inc  = 2'd1;
          state_nxt = IDLE;
          if (accept) begin
            if (entry_empty) begin
              done_inc = 2'd2;
            end else begin
              capture   = 1'b1;
              retry_nxt = '0;
              state_nxt = REQ;
            end
          end
        end else if (resp_retry) begin
          if (retry_cnt == RCNT_W'(MAX_RETRY)) begin
            err_nxt   = 1'b1;
            done_inc  = 2'd1;
            state_nxt = IDLE;
          end else begin
            retry_nxt = retry_cnt + RCNT_W'(1);
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      hold_strb <= '0;
      retry_cnt <= '0;
      done_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      done_cnt  <= done_cnt + 16'(done_inc);
      err_q     <= err_nxt;
      if (capture) begin
        hold_addr <= sb_entry_addr & ~ADDR_W'(3);
        hold_data <= sb_entry_data;
        hold_strb <= sb_entry_wstrb;
      end
    end
  end

  assign wr_req_valid_o = (state == REQ);
  assign busy_o         = (state != IDLE);
  assign wr_addr_o      = hold_addr;
  assign wr_data_o      = hold_data;
  assign wr_strb_o      = hold_strb;
  assign err_o          = err_q;
  assign done_cnt_o     = done_cnt;

endmodule

// File: tb/tb_sb_drain_unit.sv
// Directed bench for sb_drain_unit with a 1-cycle write-port model (optional stall/retries).
module tb_sb_drain_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sb_entry_valid, sb_entry_ready;
  logic [31:0] sb_entry_addr, sb_entry_data;
  logic [3:0]  sb_entry_wstrb;
  logic        wr_req_valid_o, wr_req_ready_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [3:0]  wr_strb_o;
  logic        wr_resp_valid_i, wr_resp_retry_i;
  logic        busy_o, err_o;
  logic [15:0] done_cnt_o;

  sb_drain_unit #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_entry_valid(sb_entry_valid), .sb_entry_ready(sb_entry_ready),
    .sb_entry_addr(sb_entry_addr), .sb_entry_data(sb_entry_data), .sb_entry_wstrb(sb_entry_wstrb),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .wr_resp_valid_i(wr_resp_valid_i), .wr_resp_retry_i(wr_resp_retry_i),
    .busy_o(busy_o), .err_o(err_o), .done_cnt_o(done_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stall_left = 0;
  int   retries_left = 0;
  logic hs_seen = 1'b0;
  req_t reqs[$];
  int   err_hi = 0;
  int   bypass_acc = 0;
  int   last_acc_edge = 0;
  int   idle_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port model: drives one cycle after each edge; answers the cycle after a handshake.
  always @(posedge clk) begin
    #1;
    wr_resp_valid_i = hs_seen;
    wr_resp_retry_i = hs_seen && (retries_left > 0);
    if (hs_seen && retries_left > 0) retries_left--;
    wr_req_ready_i = wr_req_valid_o && (stall_left == 0);
    if (wr_req_valid_o && stall_left > 0) stall_left--;
  end

  // Mid-cycle monitor: values seen here are what the next rising edge acts on.
  always @(negedge clk) begin
    hs_seen = wr_req_valid_o && wr_req_ready_i;
    if (wr_req_valid_o && wr_req_ready_i) reqs.push_back('{wr_addr_o, wr_data_o, wr_strb_o});
    if (err_o) err_hi++;
    if (sb_entry_valid && sb_entry_ready) begin
      if (busy_o) bypass_acc++;
      last_acc_edge = cyc + 1;
    end
    if (rst_n && wr_resp_valid_i && !(busy_o && !wr_req_valid_o)) begin
      tests++; fails++;
      $display("FAIL resp_outside_resp at cycle %0d", cyc);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    sb_entry_valid = 1'b1;
    sb_entry_addr  = a;
    sb_entry_data  = d;
    sb_entry_wstrb = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_entry_ready) begin ok = 1'b1; break; end
    end
    step();
    sb_entry_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout addr=%h never accepted within 100 cycles", a);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; idle_edge = cyc; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL idle_timeout busy_o still 1 after 200 cycles");
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sb_entry_valid = 1'b0; sb_entry_addr = '0; sb_entry_data = '0; sb_entry_wstrb = '0;
    wr_req_ready_i = 1'b0; wr_resp_valid_i = 1'b0; wr_resp_retry_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({wr_req_valid_o, busy_o, err_o, sb_entry_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_ctrl {req_valid,busy,err,ready}=%b expected 0001",
               {wr_req_valid_o, busy_o, err_o, sb_entry_ready});
    end
    tests++;
    if (done_cnt_o !== 16'd0) begin
      fails++; $display("FAIL reset_done done_cnt_o=%0d expected 0", done_cnt_o);
    end
    tests++;
    if ({wr_addr_o, wr_data_o, wr_strb_o} !== 68'd0) begin
      fails++; $display("FAIL reset_hold addr=%h data=%h strb=%h expected all 0", wr_addr_o, wr_data_o, wr_strb_o);
    end
    step();
  endtask

  task automatic test_single();
    reqs.delete(); err_hi = 0;
    send(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_idle();
    tests++;
    if (reqs.size() !== 1) begin
      fails++; $display("FAIL single_count requests=%0d expected 1", reqs.size());
    end else begin
      tests++;
      if ({reqs[0].a, reqs[0].d, reqs[0].s} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'hF}) begin
        fails++; $display("FAIL single_req got %h/%h/%h expected 10000004/deadbeef/f", reqs[0].a, reqs[0].d, reqs[0].s);
      end
    end
    tests++;
    if ({done_cnt_o, busy_o} !== {16'd1, 1'b0}) begin
      fails++; $display("FAIL single_done done=%0d busy=%b expected 1/0", done_cnt_o, busy_o);
    end
    tests++;
    if (err_hi !== 0) begin
      fails++; $display("FAIL single_err err_o high %0d cycles expected 0", err_hi);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [4] = '{32'h2000, 32'h2004, 32'h200C, 32'h2010};
    logic [31:0] ed [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [3:0]  es [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
    int acc0;
    logic [15:0] d0;
    reqs.delete(); bypass_acc = 0; d0 = done_cnt_o;
    send(32'h2000, 32'h1111_1111, 4'hF);
    acc0 = last_acc_edge;
    send(32'h2007, 32'h2222_2222, 4'h3);
    send(32'h200C, 32'h3333_3333, 4'hC);
    send(32'h2011, 32'h4444_4444, 4'h1);
    wait_idle();
    tests++;
    if (reqs.size() !== 4) begin
      fails++; $display("FAIL b2b_count requests=%0d expected 4", reqs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({reqs[i].a, reqs[i].d, reqs[i].s} !== {ea[i], ed[i], es[i]}) begin
          fails++; $display("FAIL b2b_req%0d got %h/%h/%h expected %h/%h/%h",
                            i, reqs[i].a, reqs[i].d, reqs[i].s, ea[i], ed[i], es[i]);
        end
      end
    end
    tests++;
    if (bypass_acc !== 3) begin
      fails++; $display("FAIL b2b_bypass accepts while busy=%0d expected 3", bypass_acc);
    end
    tests++;
    if (idle_edge - acc0 !== 8) begin
      fails++; $display("FAIL b2b_latency cycles=%0d expected 8", idle_edge - acc0);
    end
    tests++;
    if (done_cnt_o - d0 !== 16'd4) begin
      fails++; $display("FAIL b2b_done delta=%0d expected 4", done_cnt_o - d0);
    end
  endtask

  task automatic test_stall();
    logic [15:0] d0;
    reqs.delete(); d0 = done_cnt_o;
    stall_left = 5;
    send(32'h3000_0008, 32'hA5A5_5A5A, 4'h6);
    sb_entry_valid = 1'b1;
    sb_entry_addr = 32'h3000_0010; sb_entry_data = 32'h0BAD_F00D; sb_entry_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({wr_req_valid_o, wr_req_ready_i, sb_entry_ready, wr_addr_o, wr_data_o, wr_strb_o}
          !== {3'b100, 32'h3000_0008, 32'hA5A5_5A5A, 4'h6}) begin
        fails++;
        $display("FAIL stall_hold%0d v/r/rdy=%b addr=%h data=%h strb=%h expected 100/30000008/a5a55a5a/6",
                 i, {wr_req_valid_o, wr_req_ready_i, sb_entry_ready}, wr_addr_o, wr_data_o, wr_strb_o);
      end
    end
    send(32'h3000_0010, 32'h0BAD_F00D, 4'hF);
    wait_idle();
    tests++;
    if (reqs.size() !== 2 || done_cnt_o - d0 !== 16'd2) begin
      fails++; $display("FAIL stall_result requests=%0d done_delta=%0d expected 2/2", reqs.size(), done_cnt_o - d0);
    end
  endtask

  task automatic test_retry_ok();
    logic [15:0] d0;
    int same;
    reqs.delete(); err_hi = 0; d0 = done_cnt_o;
    retries_left = 2;
    send(32'h4000_0020, 32'h1234_5678, 4'h9);
    wait_idle();
    same = 0;
    foreach (reqs[i])
      if ({reqs[i].a, reqs[i].d, reqs[i].s} === {32'h4000_0020, 32'h1234_5678, 4'h9}) same++;
    tests++;
    if (reqs.size() !== 3 || same !== 3) begin
      fails++; $display("FAIL retry_ok_reqs requests=%0d matching=%0d expected 3/3", reqs.size(), same);
    end
    tests++;
    if (err_hi !== 0 || done_cnt_o - d0 !== 16'd1) begin
      fails++; $display("FAIL retry_ok_done err_cycles=%0d done_delta=%0d expected 0/1", err_hi, done_cnt_o - d0);
    end
  endtask

  task automatic test_retry_err();
    logic [15:0] d0;
    reqs.delete(); err_hi = 0; d0 = done_cnt_o;
    retries_left = 4;
    send(32'h5000_0000, 32'hFACE_CAFE, 4'hF);
    wait_idle();
    tests++;
    if (reqs.size() !== 4) begin
      fails++; $display("FAIL retry_err_reqs requests=%0d expected 4", reqs.size());
    end
    tests++;
    if (err_hi !== 1 || done_cnt_o - d0 !== 16'd1) begin
      fails++; $display("FAIL retry_err_pulse err_cycles=%0d done_delta=%0d expected 1/1", err_hi, done_cnt_o - d0);
    end
    send(32'h5000_0040, 32'h0000_0001, 4'h1);
    wait_idle();
    tests++;
    if (reqs.size() !== 5 || done_cnt_o - d0 !== 16'd2 || err_hi !== 1) begin
      fails++; $display("FAIL retry_err_next requests=%0d done_delta=%0d err_cycles=%0d expected 5/2/1",
                        reqs.size(), done_cnt_o - d0, err_hi);
    end else begin
      tests++;
      if (reqs[4].a !== 32'h5000_0040) begin
        fails++; $display("FAIL retry_err_next_addr got %h expected 50000040", reqs[4].a);
      end
    end
  endtask

  task automatic test_strb_zero_and_reset();
    logic [15:0] d0;
    reqs.delete(); d0 = done_cnt_o;
    send(32'h6000_0000, 32'hCAFE_0000, 4'h0);
    @(negedge clk);
    tests++;
    if (done_cnt_o - d0 !== 16'd1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL strb0_retire done_delta=%0d busy=%b expected 1/0", done_cnt_o - d0, busy_o);
    end
    repeat (4) step();
    tests++;
    if (reqs.size() !== 0) begin
      fails++; $display("FAIL strb0_noreq requests=%0d expected 0", reqs.size());
    end
    stall_left = 10;
    send(32'h7000_0000, 32'h7777_7777, 4'hF);
    @(negedge clk);
    tests++;
    if (wr_req_valid_o !== 1'b1) begin
      fails++; $display("FAIL rst_pre req_valid=%b expected 1", wr_req_valid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({wr_req_valid_o, busy_o, sb_entry_ready, done_cnt_o, wr_addr_o} !== {3'b001, 16'd0, 32'd0}) begin
      fails++; $display("FAIL rst_async req_valid=%b busy=%b ready=%b done=%0d addr=%h expected 0/0/1/0/0",
                        wr_req_valid_o, busy_o, sb_entry_ready, done_cnt_o, wr_addr_o);
    end
    stall_left = 0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_retry_ok();
    test_retry_err();
    test_strb_zero_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
